// File: rtl/beam_pkg.sv
// Shared constants, scan-state encoding and energy-width helper for the
// delay-and-sum beam steering blocks.
package beam_pkg;

    localparam int PCM_W    = 19;
    // Sixteen PCM channels summed need four extra bits of headroom.
    localparam int SUM_W    = PCM_W + 4;
    localparam int NUM_DIRS = 32;
    localparam int DIR_W    = $clog2(NUM_DIRS);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        DWELL,
        LOCK
    } scan_state_t;

    function automatic int energy_width(input int dwell_log2);
        return SUM_W + dwell_log2;
    endfunction

endpackage

// File: rtl/beam_energy_acc.sv
// Magnitude-of-beam accumulator; acc_next is exposed combinationally so the
// scan controller can compare the final dwell sample in its own cycle.
module beam_energy_acc
    import beam_pkg::*;
#(
    parameter int ACC_W = SUM_W + 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    enable,
    input  logic                    last,
    input  logic signed [SUM_W-1:0] beam_sum,
    output logic [ACC_W-1:0]        acc_next
);

    logic [ACC_W-1:0] acc;
    logic [SUM_W-1:0] magnitude;

    // Negating -2^(SUM_W-1) wraps to the same bit pattern, which read as
    // unsigned is exactly +2^(SUM_W-1), so no saturation is needed.
    always_comb begin
        magnitude = beam_sum[SUM_W-1] ? $unsigned(-beam_sum) : $unsigned(beam_sum);
        acc_next  = acc + ACC_W'(magnitude);
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= last ? '0 : acc_next;
        end
    end

endmodule

// File: rtl/beam_scan_controller.sv
// Steers the beamformer through a range of directions, integrates beam energy
// per direction and locks delay_select onto the strongest one.
module beam_scan_controller
    import beam_pkg::*;
#(
    parameter int               SETTLE_SAMPLES = 64,
    parameter int               DWELL_LOG2     = 8,
    parameter logic [DIR_W-1:0] DEFAULT_DIR    = 5'd30
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 continuous,
    input  logic [DIR_W-1:0]                     first_dir,
    input  logic [DIR_W-1:0]                     last_dir,
    input  logic                                 sample_valid,
    input  logic signed [SUM_W-1:0]              beam_sum,
    output logic [DIR_W-1:0]                     delay_select,
    output logic                                 busy,
    output logic                                 done,
    output logic [DIR_W-1:0]                     best_dir,
    output logic [energy_width(DWELL_LOG2)-1:0]  best_energy,
    output logic                                 dir_valid,
    output logic [energy_width(DWELL_LOG2)-1:0]  dir_energy
);

    localparam int               EW          = energy_width(DWELL_LOG2);
    localparam int               SCW         = $clog2(SETTLE_SAMPLES + 1);
    localparam logic [SCW-1:0]   SETTLE_LAST = SCW'(SETTLE_SAMPLES - 1);

    scan_state_t       state, state_next;
    logic [DIR_W-1:0]  first_r, last_r;
    logic [SCW-1:0]    settle_cnt;
    logic [DWELL_LOG2-1:0] dwell_cnt;
    logic [EW-1:0]     run_best_energy;
    logic [DIR_W-1:0]  run_best_dir;
    logic [EW-1:0]     acc_next;

    logic take_start, restart, settle_done, dwell_strobe, dwell_last;
    logic at_last_dir, new_best, acc_clear;
    logic [DIR_W-1:0]  win_dir;
    logic [EW-1:0]     win_energy;

    beam_energy_acc #(.ACC_W(EW)) u_acc (
        .clk      (clk),
        .rst      (rst),
        .clear    (acc_clear),
        .enable   (dwell_strobe),
        .last     (dwell_last),
        .beam_sum (beam_sum),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (take_start) state_next = SETTLE;
            SETTLE:  if (settle_done) state_next = DWELL;
            DWELL:   if (dwell_last) state_next = at_last_dir ? LOCK : SETTLE;
            LOCK:    if (restart || take_start) state_next = SETTLE;
            default: state_next = IDLE;
        endcase
    end

    // done is high only in the LOCK entry cycle, which is the one cycle
    // where continuous is allowed to trigger a restart.
    always_comb begin
        take_start   = 1'b0;
        restart      = 1'b0;
        settle_done  = 1'b0;
        dwell_strobe = 1'b0;
        dwell_last   = 1'b0;
        case (state)
            IDLE:   take_start = start;
            SETTLE: settle_done = sample_valid && (settle_cnt == SETTLE_LAST);
            DWELL: begin
                dwell_strobe = sample_valid;
                dwell_last   = sample_valid && (&dwell_cnt);
            end
            LOCK: begin
                restart    = done && continuous;
                take_start = start && !(done && continuous);
            end
            default: ;
        endcase
        at_last_dir = (delay_select == last_r);
        new_best    = (acc_next > run_best_energy);
        win_dir     = new_best ? delay_select : run_best_dir;
        win_energy  = new_best ? acc_next : run_best_energy;
        acc_clear   = take_start || restart || settle_done;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            first_r         <= '0;
            last_r          <= '0;
            delay_select    <= DEFAULT_DIR;
            settle_cnt      <= '0;
            dwell_cnt       <= '0;
            run_best_energy <= '0;
            run_best_dir    <= DEFAULT_DIR;
            best_dir        <= DEFAULT_DIR;
            best_energy     <= '0;
            dir_energy      <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            dir_valid       <= 1'b0;
        end else begin
            dir_valid <= dwell_last;
            done      <= dwell_last && at_last_dir;

            if (take_start) begin
                first_r <= first_dir;
                last_r  <= last_dir;
            end

            if (take_start) begin
                delay_select <= first_dir;
            end else if (restart) begin
                delay_select <= first_r;
            end else if (dwell_last) begin
                delay_select <= at_last_dir ? win_dir : delay_select + 1'b1;
            end

            if (take_start || restart || dwell_last) begin
                settle_cnt <= '0;
            end else if (state == SETTLE && sample_valid) begin
                settle_cnt <= settle_cnt + 1'b1;
            end

            if (settle_done) begin
                dwell_cnt <= '0;
            end else if (dwell_strobe) begin
                dwell_cnt <= dwell_cnt + 1'b1;
            end

            if (take_start) begin
                run_best_energy <= '0;
                run_best_dir    <= first_dir;
            end else if (restart) begin
                run_best_energy <= '0;
                run_best_dir    <= first_r;
            end else if (dwell_last) begin
                run_best_energy <= win_energy;
                run_best_dir    <= win_dir;
            end

            if (dwell_last) begin
                dir_energy <= acc_next;
            end

            if (dwell_last && at_last_dir) begin
                best_dir    <= win_dir;
                best_energy <= win_energy;
            end

            if (take_start || restart) begin
                busy <= 1'b1;
            end else if (dwell_last && at_last_dir) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_beam_scan_controller.sv
// Scoreboard bench: the driver pushes expected per-direction and per-scan
// results from a strobe-counting model; a negedge monitor pops and compares.
module tb_beam_scan_controller;

    localparam int S  = 4;
    localparam int L  = 2;
    localparam int D  = 1 << L;
    localparam int EW = 23 + L;

    logic                  clk = 1'b0;
    logic                  rst, start, continuous, sample_valid;
    logic [4:0]            first_dir, last_dir;
    logic signed [22:0]    beam_sum;
    logic [4:0]            delay_select, best_dir;
    logic                  busy, done, dir_valid;
    logic [EW-1:0]         best_energy, dir_energy;

    typedef struct { longint energy; int next_dir; } dir_rec_t;
    typedef struct { int dir; longint energy; } done_rec_t;

    dir_rec_t  dir_q[$];
    done_rec_t done_q[$];
    int compared   = 0;
    int mismatched = 0;

    beam_scan_controller #(
        .SETTLE_SAMPLES (S),
        .DWELL_LOG2     (L),
        .DEFAULT_DIR    (5'd30)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .continuous   (continuous),
        .first_dir    (first_dir),
        .last_dir     (last_dir),
        .sample_valid (sample_valid),
        .beam_sum     (beam_sum),
        .delay_select (delay_select),
        .busy         (busy),
        .done         (done),
        .best_dir     (best_dir),
        .best_energy  (best_energy),
        .dir_valid    (dir_valid),
        .dir_energy   (dir_energy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sampleValue(input int mode, input int dir);
        logic signed [22:0] r;
        case (mode)
            1: return (dir == 2) ? 100 : 10;
            2: return -4194304;
            default: begin
                r = 23'($urandom);
                return int'(r);
            end
        endcase
    endfunction

    task automatic strobe(input int v);
        sample_valid = 1'b1;
        beam_sum     = 23'(v);
        tick();
        sample_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
    endtask

    // Model: scan k of direction d owns strobes [d*(S+D), (d+1)*(S+D)); the
    // last D strobes of each slot are integrated, settle strobes are noise.
    task automatic applyStimulus(input int f, input int l, input int mode, input int nscans,
                                 input int abort_after, input bit poke_start);
        int n, cnt, dir, v, best_d;
        longint acc, best_e;
        n = ((l - f) & 31) + 1;
        first_dir = 5'(f);
        last_dir  = 5'(l);
        start     = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("busy_after_start", longint'(busy), 1);
        cnt = 0;
        for (int s = 0; s < nscans; s++) begin
            best_e     = 0;
            best_d     = f;
            continuous = (s < nscans - 1);
            for (int d = 0; d < n; d++) begin
                dir = (f + d) & 31;
                for (int k = 0; k < S; k++) begin
                    strobe(sampleValue(0, dir));
                    cnt++;
                    if (cnt == abort_after) return;
                    if (poke_start && cnt == 3) begin
                        first_dir = 5'($urandom);
                        last_dir  = 5'($urandom);
                        start     = 1'b1;
                        tick();
                        start = 1'b0;
                    end
                end
                acc = 0;
                for (int k = 0; k < D; k++) begin
                    v = sampleValue(mode, dir);
                    acc += (v < 0) ? -v : v;
                    if (k == D - 1) begin
                        if (acc > best_e) begin
                            best_e = acc;
                            best_d = dir;
                        end
                        dir_q.push_back('{energy: acc, next_dir: (d == n - 1) ? best_d : ((dir + 1) & 31)});
                        if (d == n - 1) done_q.push_back('{dir: best_d, energy: best_e});
                    end
                    strobe(v);
                    cnt++;
                    if (cnt == abort_after) return;
                end
            end
            sample_valid = 1'b0;
            tick();
        end
        continuous = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (dir_q.size() + done_q.size()) > 0; i++) tick();
        checkOutput("queue_drain", longint'(dir_q.size() + done_q.size()), 0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_delay_select"}, longint'(delay_select), 30);
        checkOutput({tag, "_best_dir"}, longint'(best_dir), 30);
        checkOutput({tag, "_best_energy"}, longint'(best_energy), 0);
        checkOutput({tag, "_dir_energy"}, longint'(dir_energy), 0);
        checkOutput({tag, "_busy"}, longint'(busy), 0);
        checkOutput({tag, "_done"}, longint'(done), 0);
        checkOutput({tag, "_dir_valid"}, longint'(dir_valid), 0);
    endtask

    always @(negedge clk) begin : monitor
        dir_rec_t  dr;
        done_rec_t nr;
        if (!rst && dir_valid) begin
            checkOutput("dir_valid_expected", longint'(dir_q.size() > 0), 1);
            if (dir_q.size() > 0) begin
                dr = dir_q.pop_front();
                checkOutput("dir_energy", longint'(dir_energy), dr.energy);
                checkOutput("dir_next_select", longint'(delay_select), longint'(dr.next_dir));
            end
        end
        if (!rst && done) begin
            checkOutput("done_expected", longint'(done_q.size() > 0), 1);
            if (done_q.size() > 0) begin
                nr = done_q.pop_front();
                checkOutput("best_dir", longint'(best_dir), longint'(nr.dir));
                checkOutput("best_energy", longint'(best_energy), nr.energy);
                checkOutput("lock_select", longint'(delay_select), longint'(nr.dir));
                checkOutput("done_busy", longint'(busy), 0);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog expired compared=%0d", compared);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        continuous   = 1'b0;
        sample_valid = 1'b0;
        beam_sum     = '0;
        first_dir    = '0;
        last_dir     = '0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (20) tick();
        checkResetValues("idle");

        $display("[TB] range 0..3 with a strong direction 2");
        applyStimulus(0, 3, 1, 1, -1, 1'b0);
        drain();
        checkOutput("t2_best_dir", longint'(best_dir), 2);
        checkOutput("t2_best_energy", longint'(best_energy), 400);
        checkOutput("t2_delay_select", longint'(delay_select), 2);

        $display("[TB] wrapping range 30..1 with full-scale negative input");
        applyStimulus(30, 1, 2, 1, -1, 1'b0);
        drain();
        checkOutput("t3_best_dir", longint'(best_dir), 30);
        checkOutput("t3_best_energy", longint'(best_energy), 16777216);

        $display("[TB] start pulsed mid-scan");
        applyStimulus(10, 12, 0, 1, -1, 1'b1);
        drain();

        $display("[TB] reset during dwell of direction 1");
        applyStimulus(0, 3, 0, 1, S + D + S + 2, 1'b0);
        rst = 1'b1;
        tick();
        checkResetValues("abort");
        rst = 1'b0;
        repeat (10) tick();
        checkOutput("abort_pending", longint'(dir_q.size() + done_q.size()), 0);

        $display("[TB] continuous single-direction scan");
        applyStimulus(5, 5, 0, 3, -1, 1'b0);
        drain();
        checkOutput("cont_delay_select", longint'(delay_select), 5);

        $display("[TB] randomized ranges");
        for (int t = 0; t < 6; t++) begin
            applyStimulus($urandom_range(0, 31), $urandom_range(0, 31), 0, (t == 2) ? 2 : 1, -1, 1'b0);
            drain();
        end

        repeat (5) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/beam_scan_controller.md
# beam_scan_controller

Steering scheduler for the 16-mic delay-and-sum beamformer. It drives the 5-bit `delay_select` of the delay module through a programmable range of the 32 precomputed steering directions. At each direction it waits for the delay lines to refill, then integrates beam-output magnitude over a fixed dwell. When the range is covered it locks `delay_select` onto the direction with the highest energy.

## Interface
- `SETTLE_SAMPLES`, 64: samples discarded after each direction change; must exceed the largest table delay.
- `DWELL_LOG2`, 8: dwell length is 2^DWELL_LOG2 samples per direction.
- `DEFAULT_DIR`, 5'd30: direction driven at reset (the all-zero-delay broadside entry).
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a scan.
- `continuous` in 1: when 1, a new scan restarts automatically after each lock.
- `first_dir` in 5: first direction of the range; latched on accepted `start`.
- `last_dir` in 5: last direction of the range, inclusive; latched on accepted `start`.
- `sample_valid` in 1: one-cycle strobe, one per PCM sample period.
- `beam_sum` in 23: signed sum of the 16 delayed PCM channels; valid with `sample_valid`.
- `delay_select` out 5: registered; connects to the delay module.
- `busy` out 1: high from accepted `start` until lock.
- `done` out 1: one-cycle pulse when the scan result is updated.
- `best_dir` out 5: winning direction of the last completed scan.
- `best_energy` out 23+DWELL_LOG2: energy of `best_dir`.
- `dir_valid` out 1: one-cycle pulse per completed direction.
- `dir_energy` out 23+DWELL_LOG2: energy of the direction just completed; valid with `dir_valid`.

## Operation
- States are IDLE, SETTLE, DWELL and LOCK.
- **IDLE**
  - `start` latches the range and sets `delay_select`=`first_dir`.
  - It clears the settle counter, the accumulator and the best register, sets `busy`, and goes to SETTLE.
- **SETTLE**
  - Counts `sample_valid` strobes.
  - After `SETTLE_SAMPLES` strobes, goes to DWELL. The accumulator is zeroed.
- **DWELL**
  - Each strobe adds `|beam_sum|` to the accumulator. The magnitude is unsigned 23 bits, so -2^22 maps to 2^22 with no saturation needed.
  - On the 2^DWELL_LOG2-th strobe, acc_next is compared with best and the following happen in the same cycle:
    - `dir_valid` pulses and `dir_energy` = acc_next.
    - If acc_next > best (strict), best is updated to acc_next and the current direction. Ties keep the earlier-scanned direction.
    - If the direction was `last_dir`, the block goes to LOCK.
    - Otherwise `delay_select` = (`delay_select`+1) mod 32 and the block goes to SETTLE.
- **LOCK**
  - Entry cycle: `delay_select`=best dir, `best_dir`/`best_energy` updated, `done` pulses, `busy` drops.
  - If `continuous`=1, the block then restarts with the latched range: SETTLE at `first_dir`, `busy` high.
  - Otherwise it holds in LOCK; `start` there behaves as in IDLE.
- Range wraps: `last_dir` < `first_dir` scans `first_dir`..31, 0..`last_dir`. `first_dir`==`last_dir` scans one direction.
- `start` while `busy` is ignored; the range is not relatched.
- The first direction's energy always beats the zeroed best, so `best_dir` is always a scanned direction.
- `continuous` is sampled only in the LOCK entry cycle.

## Timing
- Reset values:
  - `delay_select`=`DEFAULT_DIR`.
  - `best_dir`=`DEFAULT_DIR`.
  - `best_energy`=0, `dir_energy`=0.
  - `busy`=0, `done`=0, `dir_valid`=0.
  - State IDLE.
- Reset mid-scan aborts within one cycle and restores all reset values; no `done` pulse is produced.
- `delay_select` changes on the clock edge after the qualifying event: accepted `start`, last dwell strobe, or LOCK entry.
- The first settle strobe counted is the first strobe strictly after the `delay_select` change.
- No sample is lost at direction boundaries: compare and step occur in the strobe's own cycle.
- `dir_valid` and `done` are registered outputs, asserted the cycle after the final strobe.
- Scan length is N·(SETTLE_SAMPLES+2^DWELL_LOG2) strobes, where N = ((`last_dir`-`first_dir`) mod 32)+1.
- `sample_valid` gaps of any length are tolerated; counters only advance on strobes.

## Structure
- Shared `beam_pkg`, containing:
  - PCM_W=19, SUM_W=23, DIR_W=5, NUM_DIRS=32.
  - Scan-state enum.
  - Energy-width function SUM_W+DWELL_LOG2.
- One sub-module, `beam_energy_acc`:
  - Magnitude plus accumulator, with clear, enable and last-sample ports.
  - Outputs acc_next combinationally for the compare.
- The FSM, counters and best-tracking stay in the top module.

## Test plan
All directed tests use SETTLE_SAMPLES=4 and DWELL_LOG2=2.
- Reset, then idle 20 cycles -> `delay_select`=30, `busy`=0, no pulses.
- Range 0..3; `beam_sum`=+100 on dir 2 and +10 elsewhere -> `dir_energy` 40,40,400,40, then `done` with `best_dir`=2, `best_energy`=400, `delay_select`=2.
- Range 30..1 with `beam_sum`=-4194304 constant -> directions visited 30,31,0,1 in order, each energy 16777216, `best_dir`=30 (tie rule).
- `start` asserted mid-scan -> ignored, range unchanged.
- `rst` pulsed during DWELL of dir 1 -> all reset values next cycle, no `done` pulse.
- `continuous`=1, range 5..5 -> `done` every 8 strobes, `delay_select` stays 5.
